// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the 12-bit SPI link
// Contents:
//   SPI_WORD_W      word width used by both master and slave
//   spi_tx_state_t  transmitter frame states
package spi_pkg;

   localparam int SPI_WORD_W = 12;

   typedef enum logic [1:0] {
      IDLE,
      START,
      SHIFT,
      TAIL
   } spi_tx_state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// rtl/spi_sclk_gen.sv - free-running SPI clock generator with edge strobes
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-low reset
//   sclk  out  registered SPI clock, low out of reset
//   rise  out  high in the clk cycle whose closing edge takes sclk 0->1
//   fall  out  high in the clk cycle whose closing edge takes sclk 1->0
module spi_sclk_gen #(
   parameter int CLK_DIV = 10
) (
   input  logic clk,
   input  logic rst,
   output logic sclk,
   output logic rise,
   output logic fall
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt;
   logic          wrap;

   assign wrap = (cnt == CW'(CLK_DIV - 1));

   // Strobes lead the toggle by one cycle so that logic using them updates
   // on the very edge that moves sclk.
   assign rise = wrap & ~sclk;
   assign fall = wrap & sclk;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt  <= '0;
         sclk <= 1'b0;
      end else if (wrap) begin
         cnt  <= '0;
         sclk <= ~sclk;
      end else begin
         cnt  <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/spi_master_tx.sv
// rtl/spi_master_tx.sv - SPI master transmitter, LSB first, one-word holding buffer
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous active-low reset
//   newd   in   new-word strobe, din valid in the same cycle
//   din    in   word to transmit
//   ready  out  holding buffer empty
//   busy   out  transfer in progress
//   done   out  one-cycle pulse at the end of a transfer
//   ovf    out  one-cycle pulse when newd arrives while the buffer is full
//   sclk   out  free-running SPI clock
//   cs     out  chip select, active low
//   mosi   out  serial data, changes on sclk falling edges
module spi_master_tx
   import spi_pkg::*;
#(
   parameter int DATA_W  = SPI_WORD_W,
   parameter int CLK_DIV = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              newd,
   input  logic [DATA_W-1:0] din,
   output logic              ready,
   output logic              busy,
   output logic              done,
   output logic              ovf,
   output logic              sclk,
   output logic              cs,
   output logic              mosi
);

   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   spi_tx_state_t     state;
   logic [DATA_W-1:0] hold;
   logic [DATA_W-1:0] shift;
   logic [BW-1:0]     bitcnt;
   logic              pending;
   logic              rise;
   logic              fall;

   spi_sclk_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sclk_gen (
      .clk  (clk),
      .rst  (rst),
      .sclk (sclk),
      .rise (rise),
      .fall (fall)
   );

   assign ready = ~pending;
   assign busy  = (state != IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         hold    <= '0;
         shift   <= '0;
         bitcnt  <= '0;
         pending <= 1'b0;
         cs      <= 1'b1;
         mosi    <= 1'b0;
         done    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         done <= 1'b0;
         // The overflow decision looks at the registered buffer flag, so a
         // word offered in the cycle the buffer drains is still refused.
         ovf  <= newd & pending;
         // Capture and drain are exclusive: capture needs pending=0,
         // draining in IDLE needs pending=1.
         if (newd && !pending) begin
            hold    <= din;
            pending <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (fall && pending) begin
                  shift   <= hold;
                  pending <= 1'b0;
                  cs      <= 1'b0;
                  state   <= START;
               end
            end
            // One full sclk period with cs low and mosi idle lets the slave
            // see cs asserted on a rise before the first data bit.
            START: begin
               if (fall) begin
                  mosi   <= shift[0];
                  bitcnt <= '0;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               if (fall) begin
                  if (bitcnt == BW'(DATA_W - 1)) begin
                     cs    <= 1'b1;
                     mosi  <= 1'b0;
                     state <= TAIL;
                  end else begin
                     shift  <= shift >> 1;
                     mosi   <= shift[1];
                     bitcnt <= bitcnt + BW'(1);
                  end
               end
            end
            // The rise after cs deasserts is the slave's completion edge.
            TAIL: begin
               if (rise) begin
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_tx.sv
// tb/tb_spi_master_tx.sv - self-checking bench for spi_master_tx at CLK_DIV 2, 1 and 7
module tb_spi_master_tx;

   typedef struct {
      int          k;
      logic [11:0] word;
      int          nbits;
      int          cs_low;
      int          first_one;
      int          gap;
   } frame_t;

   typedef struct {
      int          k;
      logic [11:0] word;
   } exp_t;

   typedef struct {
      int          k;
      logic [11:0] din;
      logic [11:0] word;
      int          cs_low;
      int          first_one;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  newd_v = '0;
   logic [11:0] din_s [3];
   logic [2:0]  ready_v, busy_v, done_v, ovf_v, sclk_v, cs_v, mosi_v;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      spi_master_tx #(
         .DATA_W  (12),
         .CLK_DIV (g == 0 ? 2 : (g == 1 ? 1 : 7))
      ) dut (
         .clk   (clk),
         .rst   (rst),
         .newd  (newd_v[g]),
         .din   (din_s[g]),
         .ready (ready_v[g]),
         .busy  (busy_v[g]),
         .done  (done_v[g]),
         .ovf   (ovf_v[g]),
         .sclk  (sclk_v[g]),
         .cs    (cs_v[g]),
         .mosi  (mosi_v[g])
      );
   end

   function automatic int div_of(input int k);
      return (k == 0) ? 2 : ((k == 1) ? 1 : 7);
   endfunction

   // Slave-side view of each link plus host-side expectations.
   logic        prev_sclk [3];
   logic        prev_cs [3];
   logic        in_frame [3];
   logic        m_pending [3];
   logic        m_busy [3];
   logic        exp_ovf [3];
   logic [11:0] wordm [3];
   int          nbits [3];
   int          rise_idx [3];
   int          first_one [3];
   int          lo_cnt [3];
   int          hi_cnt [3];
   int          last_low [3];
   int          gap [3];
   int          toggles [3];
   int          ovf_cnt [3];
   frame_t      fq [$];
   exp_t        exp_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic reset_model();
      for (int k = 0; k < 3; k++) begin
         prev_sclk[k] = 1'b0;
         prev_cs[k]   = 1'b1;
         in_frame[k]  = 1'b0;
         m_pending[k] = 1'b0;
         m_busy[k]    = 1'b0;
         exp_ovf[k]   = 1'b0;
         nbits[k]     = 0;
         lo_cnt[k]    = 0;
         hi_cnt[k]    = 0;
         last_low[k]  = 0;
         gap[k]       = 0;
      end
      fq.delete();
      exp_q.delete();
   endtask

   task automatic mon(input int k);
      logic   s, c, m, rise_e, exp_done;
      frame_t f;
      s = sclk_v[k];
      c = cs_v[k];
      m = mosi_v[k];
      rise_e   = !prev_sclk[k] && s;
      exp_done = 1'b0;
      if (prev_sclk[k] != s) toggles[k]++;
      if (prev_cs[k] && !c) begin
         gap[k]       = hi_cnt[k];
         lo_cnt[k]    = 0;
         m_pending[k] = 1'b0;
         m_busy[k]    = 1'b1;
      end
      if (!prev_cs[k] && c) last_low[k] = lo_cnt[k];
      if (c) hi_cnt[k]++;
      else begin
         lo_cnt[k]++;
         hi_cnt[k] = 0;
      end
      if (rise_e) begin
         if (!c) begin
            if (!in_frame[k]) begin
               in_frame[k]  = 1'b1;
               rise_idx[k]  = 1;
               nbits[k]     = 0;
               wordm[k]     = '0;
               first_one[k] = 0;
               chk($sformatf("detect_mosi[%0d]", k), m, 0);
            end else begin
               rise_idx[k]++;
               if (nbits[k] < 12) wordm[k][nbits[k]] = m;
               if (m && first_one[k] == 0) first_one[k] = rise_idx[k];
               nbits[k]++;
            end
         end else if (in_frame[k]) begin
            exp_done    = 1'b1;
            in_frame[k] = 1'b0;
            m_busy[k]   = 1'b0;
            f.k         = k;
            f.word      = wordm[k];
            f.nbits     = nbits[k];
            f.cs_low    = last_low[k];
            f.first_one = first_one[k];
            f.gap       = gap[k];
            fq.push_back(f);
         end
      end
      chk($sformatf("done[%0d]", k), done_v[k], exp_done);
      chk($sformatf("ovf[%0d]", k), ovf_v[k], exp_ovf[k]);
      chk($sformatf("ready[%0d]", k), ready_v[k], !m_pending[k]);
      chk($sformatf("busy[%0d]", k), busy_v[k], m_busy[k]);
      if (ovf_v[k]) ovf_cnt[k]++;
      exp_ovf[k]   = 1'b0;
      prev_sclk[k] = s;
      prev_cs[k]   = c;
   endtask

   task automatic tick();
      @(negedge clk);
      for (int k = 0; k < 3; k++) mon(k);
   endtask

   task automatic send(input int k, input logic [11:0] w);
      exp_t e;
      newd_v[k] = 1'b1;
      din_s[k]  = w;
      if (m_pending[k]) exp_ovf[k] = 1'b1;
      else begin
         m_pending[k] = 1'b1;
         e.k    = k;
         e.word = w;
         exp_q.push_back(e);
      end
      tick();
      newd_v[k] = 1'b0;
   endtask

   task automatic wait_frames(input int n, input int budget);
      int t;
      t = 0;
      while (fq.size() < n && t < budget) begin
         tick();
         t++;
      end
      chk("frame_wait_in_budget", fq.size() >= n, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_sclk"}, sclk_v, 3'b000);
      chk({tag, "_cs"}, cs_v, 3'b111);
      chk({tag, "_mosi"}, mosi_v, 3'b000);
      chk({tag, "_done"}, done_v, 3'b000);
      chk({tag, "_ovf"}, ovf_v, 3'b000);
      chk({tag, "_ready"}, ready_v, 3'b111);
      chk({tag, "_busy"}, busy_v, 3'b000);
   endtask

   vec_t   tbl [8];
   frame_t f;
   frame_t f2;
   exp_t   e;
   int     first_hi [3];
   int     viol [3];
   int     t;
   int     nw;
   int     ovf_before;

   initial begin
      tbl[0] = '{0, 12'hA5C, 12'hA5C, 52, 4};
      tbl[1] = '{0, 12'h001, 12'h001, 52, 2};
      tbl[2] = '{0, 12'h0F0, 12'h0F0, 52, 6};
      tbl[3] = '{1, 12'h800, 12'h800, 26, 13};
      tbl[4] = '{1, 12'h000, 12'h000, 26, 0};
      tbl[5] = '{2, 12'h800, 12'h800, 182, 13};
      tbl[6] = '{2, 12'hFFF, 12'hFFF, 182, 2};
      tbl[7] = '{1, 12'h3C3, 12'h3C3, 26, 2};

      for (int k = 0; k < 3; k++) begin
         din_s[k]   = '0;
         toggles[k] = 0;
         ovf_cnt[k] = 0;
         first_hi[k] = 0;
      end
      reset_model();

      // Power-on reset.
      #1 rst = 1'b0;
      #1 check_reset_outputs("por");
      repeat (3) @(negedge clk);
      rst = 1'b1;
      reset_model();

      // First sclk toggle is a rise after CLK_DIV clk edges.
      for (int i = 1; i <= 10; i++) begin
         tick();
         for (int k = 0; k < 3; k++)
            if (sclk_v[k] && first_hi[k] == 0) first_hi[k] = i;
      end
      for (int k = 0; k < 3; k++) chk($sformatf("first_rise_delay[%0d]", k), first_hi[k], div_of(k));

      // Idle window.
      for (int k = 0; k < 3; k++) begin
         toggles[k] = 0;
         viol[k]    = 0;
      end
      repeat (100) begin
         tick();
         for (int k = 0; k < 3; k++)
            if (cs_v[k] !== 1'b1 || mosi_v[k] !== 1'b0 || busy_v[k] !== 1'b0 || done_v[k] !== 1'b0)
               viol[k]++;
      end
      for (int k = 0; k < 3; k++) chk($sformatf("idle_violations[%0d]", k), viol[k], 0);
      chk("idle_toggles_div2", toggles[0], 50);
      chk("idle_toggles_div1", toggles[1], 100);
      chk("idle_toggles_div7", (toggles[2] == 14 || toggles[2] == 15), 1);

      // Single-frame vectors.
      for (int i = 0; i < 8; i++) begin
         tick();
         send(tbl[i].k, tbl[i].din);
         wait_frames(1, 400);
         if (fq.size() > 0) begin
            f = fq.pop_front();
            chk($sformatf("vec%0d_inst", i), f.k, tbl[i].k);
            chk($sformatf("vec%0d_word", i), f.word, tbl[i].word);
            chk($sformatf("vec%0d_nbits", i), f.nbits, 12);
            chk($sformatf("vec%0d_cs_low_clk", i), f.cs_low, tbl[i].cs_low);
            chk($sformatf("vec%0d_first_one_rise", i), f.first_one, tbl[i].first_one);
         end
         exp_q.delete();
      end

      // Back-to-back: second word queued while the first shifts.
      ovf_before = ovf_cnt[0];
      tick();
      send(0, 12'h001);
      repeat (6) tick();
      send(0, 12'hFFF);
      wait_frames(2, 400);
      if (fq.size() >= 2) begin
         f  = fq.pop_front();
         f2 = fq.pop_front();
         chk("b2b_word1", f.word, 12'h001);
         chk("b2b_word2", f2.word, 12'hFFF);
         chk("b2b_gap_clk", f2.gap, 2 * div_of(0));
         chk("b2b_cs_low2", f2.cs_low, 52);
      end
      chk("b2b_no_ovf", ovf_cnt[0] - ovf_before, 0);
      exp_q.delete();

      // Overflow: third word offered while the buffer is full.
      ovf_before = ovf_cnt[0];
      tick();
      send(0, 12'h456);
      repeat (6) tick();
      send(0, 12'h789);
      repeat (2) tick();
      send(0, 12'h123);
      wait_frames(2, 400);
      if (fq.size() >= 2) begin
         f  = fq.pop_front();
         f2 = fq.pop_front();
         chk("ovf_word1", f.word, 12'h456);
         chk("ovf_word2", f2.word, 12'h789);
      end
      repeat (150) tick();
      chk("ovf_dropped_word_absent", fq.size(), 0);
      chk("ovf_pulse_count", ovf_cnt[0] - ovf_before, 1);
      fq.delete();
      exp_q.delete();

      // Randomised traffic per instance.
      for (int k = 0; k < 3; k++) begin
         nw = (k == 2) ? 8 : 20;
         for (int i = 0; i < nw; i++) begin
            repeat ($urandom_range(0, 40 * div_of(k))) tick();
            send(k, 12'($urandom));
         end
         wait_frames(exp_q.size(), 120 * div_of(k) + 50);
         while (exp_q.size() > 0 && fq.size() > 0) begin
            e = exp_q.pop_front();
            f = fq.pop_front();
            chk($sformatf("rnd%0d_inst", k), f.k, e.k);
            chk($sformatf("rnd%0d_word", k), f.word, e.word);
            chk($sformatf("rnd%0d_nbits", k), f.nbits, 12);
            chk($sformatf("rnd%0d_cs_low_clk", k), f.cs_low, 13 * 2 * div_of(k));
         end
         chk($sformatf("rnd%0d_leftover", k), exp_q.size() + fq.size(), 0);
         fq.delete();
         exp_q.delete();
      end

      // Reset in the middle of a frame.
      tick();
      send(0, 12'h3C3);
      t = 0;
      while (nbits[0] != 5 && t < 400) begin
         tick();
         t++;
      end
      chk("midrst_reached_bit5", nbits[0], 5);
      #2 rst = 1'b0;
      #1 check_reset_outputs("midrst");
      reset_model();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      reset_model();
      tick();
      send(0, 12'h0F0);
      wait_frames(1, 400);
      if (fq.size() > 0) begin
         f = fq.pop_front();
         chk("post_rst_word", f.word, 12'h0F0);
         chk("post_rst_cs_low", f.cs_low, 52);
      end
      repeat (100) tick();
      chk("post_rst_no_extra_frame", fq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
